// File: rtl/sparse_block_compact_stream.sv
// rtl/sparse_block_compact_stream.sv - streams the non-zero blocks of a block-sparse vector over OUT_BLOCK_NUM lanes
// Optional SPARSE_COMPACT_SKIP_EMPTY_EN: all-zero vectors are consumed without emitting a beat.
module sparse_block_compact_stream #(
    parameter int IN_BLOCK_NUM  = 4,
    parameter int BLOCK_SIZE    = 4,
    parameter int OUT_BLOCK_NUM = 2,
    parameter int IN_WIDTH      = 16,
    localparam int IDX_WIDTH    = (IN_BLOCK_NUM > 1) ? $clog2(IN_BLOCK_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_BLOCK_NUM-1:0] zero_mask_in,
    input  logic [IN_WIDTH-1:0]     data_in [IN_BLOCK_NUM*BLOCK_SIZE],
    input  logic                    data_in_valid,
    output logic                    data_in_ready,
    output logic [IN_WIDTH-1:0]     data_out [OUT_BLOCK_NUM*BLOCK_SIZE],
    output logic [IDX_WIDTH-1:0]    data_out_block_idx [OUT_BLOCK_NUM],
    output logic [OUT_BLOCK_NUM-1:0] data_out_block_valid,
    output logic                    data_out_last,
    output logic                    data_out_valid,
    input  logic                    data_out_ready
);

    localparam int N_IN  = IN_BLOCK_NUM * BLOCK_SIZE;
    localparam int N_OUT = OUT_BLOCK_NUM * BLOCK_SIZE;

    generate
        if (OUT_BLOCK_NUM < 1 || OUT_BLOCK_NUM > IN_BLOCK_NUM) begin : g_bad_cfg
            $error("OUT_BLOCK_NUM must be within 1..IN_BLOCK_NUM");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t                    state_q, state_d;
    logic                      ready_en_q;
    logic [IN_BLOCK_NUM-1:0]   mask_q;
    logic [IN_WIDTH-1:0]       vec_q [N_IN];
    logic [IN_WIDTH-1:0]       dout_q [N_OUT];
    logic [IDX_WIDTH-1:0]      idx_q [OUT_BLOCK_NUM];
    logic [OUT_BLOCK_NUM-1:0]  bv_q;
    logic                      valid_q;
    logic                      last_q;

    logic                      out_hs;
    logic                      in_hs;
    logic                      load;
    logic                      clear;

    logic [IN_BLOCK_NUM-1:0]   src_mask;
    logic [IN_WIDTH-1:0]       src_data [N_IN];
    logic [IN_BLOCK_NUM-1:0]   beat_rem;
    logic [IN_WIDTH-1:0]       beat_data [N_OUT];
    logic [IDX_WIDTH-1:0]      beat_idx [OUT_BLOCK_NUM];
    logic [OUT_BLOCK_NUM-1:0]  beat_bv;
    logic                      beat_last;

    // ready_en_q keeps the input closed until the first clock after reset release
    assign out_hs        = valid_q && data_out_ready;
    assign data_in_ready = ready_en_q && ((state_q == S_IDLE) || (out_hs && last_q));
    assign in_hs         = data_in_valid && data_in_ready;

    // A fresh vector forms its first beat straight from the inputs; later beats use the held copy
    always_comb begin
        src_mask = in_hs ? zero_mask_in : mask_q;
        for (int i = 0; i < N_IN; i++) begin
            src_data[i] = in_hs ? data_in[i] : vec_q[i];
        end
    end

    always_comb begin : beat_form
        logic [IN_BLOCK_NUM-1:0] rem;
        logic                    found;
        rem     = src_mask;
        found   = 1'b0;
        beat_bv = '0;
        for (int l = 0; l < OUT_BLOCK_NUM; l++) begin
            beat_idx[l] = '0;
            for (int e = 0; e < BLOCK_SIZE; e++) begin
                beat_data[l*BLOCK_SIZE+e] = '0;
            end
        end
        // each lane claims the lowest-indexed block still pending
        for (int l = 0; l < OUT_BLOCK_NUM; l++) begin
            found = 1'b0;
            for (int b = 0; b < IN_BLOCK_NUM; b++) begin
                if (!found && !rem[b]) begin
                    found       = 1'b1;
                    rem[b]      = 1'b1;
                    beat_bv[l]  = 1'b1;
                    beat_idx[l] = IDX_WIDTH'(b);
                    for (int e = 0; e < BLOCK_SIZE; e++) begin
                        beat_data[l*BLOCK_SIZE+e] = src_data[b*BLOCK_SIZE+e];
                    end
                end
            end
        end
        beat_rem  = rem;
        beat_last = &rem;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clear   = 1'b0;
        if (in_hs) begin
`ifdef SPARSE_COMPACT_SKIP_EMPTY_EN
            if (&zero_mask_in) begin
                state_d = S_IDLE;
                clear   = 1'b1;
            end else begin
                state_d = S_EMIT;
                load    = 1'b1;
            end
`else
            state_d = S_EMIT;
            load    = 1'b1;
`endif
        end else if (out_hs) begin
            if (last_q) begin
                state_d = S_IDLE;
                clear   = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ready_en_q <= 1'b0;
            mask_q     <= '0;
            bv_q       <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                vec_q[i] <= '0;
            end
            for (int i = 0; i < N_OUT; i++) begin
                dout_q[i] <= '0;
            end
            for (int l = 0; l < OUT_BLOCK_NUM; l++) begin
                idx_q[l] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (in_hs) begin
                for (int i = 0; i < N_IN; i++) begin
                    vec_q[i] <= data_in[i];
                end
            end
            if (load) begin
                mask_q  <= beat_rem;
                bv_q    <= beat_bv;
                valid_q <= 1'b1;
                last_q  <= beat_last;
                for (int i = 0; i < N_OUT; i++) begin
                    dout_q[i] <= beat_data[i];
                end
                for (int l = 0; l < OUT_BLOCK_NUM; l++) begin
                    idx_q[l] <= beat_idx[l];
                end
            end else if (clear) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign data_out             = dout_q;
    assign data_out_block_idx   = idx_q;
    assign data_out_block_valid = bv_q;
    assign data_out_last        = last_q;
    assign data_out_valid       = valid_q;

endmodule

// File: tb/tb_sparse_block_compact_stream.sv
// tb/tb_sparse_block_compact_stream.sv - self-checking bench for sparse_block_compact_stream
module tb_sparse_block_compact_stream;

    localparam int IB = 4;
    localparam int BS = 4;
    localparam int OB = 2;
    localparam int W  = 16;
    localparam int IW = 2;
    localparam int VW = IB * BS * W;

    typedef struct packed {
        logic             last;
        logic [OB-1:0]    bv;
        logic [OB*IW-1:0] idx;
        logic [OB*BS*W-1:0] d;
    } beat_t;

    typedef struct packed {
        logic [IB-1:0] mask;
        logic [OB-1:0] bv;
        logic [IW-1:0] i0;
        logic [IW-1:0] i1;
        logic          last;
        logic [W-1:0]  d0;
        logic [3:0]    beats;
    } vec_t;

    logic            clk;
    logic            rst;
    logic [IB-1:0]   zero_mask_in;
    logic [W-1:0]    data_in [IB*BS];
    logic            data_in_valid;
    logic            data_in_ready;
    logic [W-1:0]    data_out [OB*BS];
    logic [IW-1:0]   data_out_block_idx [OB];
    logic [OB-1:0]   data_out_block_valid;
    logic            data_out_last;
    logic            data_out_valid;
    logic            data_out_ready;

    int     n_checks = 0;
    int     n_pass   = 0;
    beat_t  exp_q[$];
    beat_t  obs_q[$];
    bit     rand_rdy = 0;
    vec_t   tbl [7];
    logic [VW-1:0] v1, v2, v3;

    sparse_block_compact_stream #(
        .IN_BLOCK_NUM (IB),
        .BLOCK_SIZE   (BS),
        .OUT_BLOCK_NUM(OB),
        .IN_WIDTH     (W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .zero_mask_in        (zero_mask_in),
        .data_in             (data_in),
        .data_in_valid       (data_in_valid),
        .data_in_ready       (data_in_ready),
        .data_out            (data_out),
        .data_out_block_idx  (data_out_block_idx),
        .data_out_block_valid(data_out_block_valid),
        .data_out_last       (data_out_last),
        .data_out_valid      (data_out_valid),
        .data_out_ready      (data_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic beat_t sample_beat();
        beat_t bt;
        bt.last = data_out_last;
        bt.bv   = data_out_block_valid;
        for (int l = 0; l < OB; l++) bt.idx[l*IW +: IW] = data_out_block_idx[l];
        for (int e = 0; e < OB*BS; e++) bt.d[e*W +: W] = data_out[e];
        return bt;
    endfunction

    function automatic logic [VW-1:0] pack_in();
        logic [VW-1:0] v;
        for (int e = 0; e < IB*BS; e++) v[e*W +: W] = data_in[e];
        return v;
    endfunction

    function automatic logic [VW-1:0] ramp_vec();
        logic [VW-1:0] v;
        for (int e = 0; e < IB*BS; e++) v[e*W +: W] = W'(16 * (e / BS) + (e % BS));
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < VW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: list the surviving block indices, then chop the list into OB-wide beats
    task automatic model_push(input logic [IB-1:0] m, input logic [VW-1:0] dv);
        int    nz[$];
        int    nb;
        int    pos;
        beat_t bt;
        for (int b = 0; b < IB; b++) if (!m[b]) nz.push_back(b);
        nb = (nz.size() + OB - 1) / OB;
`ifndef SPARSE_COMPACT_SKIP_EMPTY_EN
        if (nb == 0) nb = 1;
`endif
        for (int k = 0; k < nb; k++) begin
            bt = '0;
            for (int l = 0; l < OB; l++) begin
                pos = k * OB + l;
                if (pos < nz.size()) begin
                    bt.bv[l] = 1'b1;
                    bt.idx[l*IW +: IW] = IW'(nz[pos]);
                    bt.d[l*BS*W +: BS*W] = dv[nz[pos]*BS*W +: BS*W];
                end
            end
            bt.last = (k == nb - 1);
            exp_q.push_back(bt);
        end
    endtask

    // Monitor: samples at negedge, so handshakes seen here complete at the next posedge
    initial begin
        beat_t cur, prev, e;
        bit    prev_stall;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 0;
            end else begin
                cur = sample_beat();
                if (prev_stall) chk("hold_stable", {data_out_valid, cur}, {1'b1, prev});
                if (data_out_valid && data_out_ready) begin
                    obs_q.push_back(cur);
                    if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("beat", cur, e);
                    end
                end
                if (data_in_valid && data_in_ready) model_push(zero_mask_in, pack_in());
                prev_stall = data_out_valid && !data_out_ready;
                prev = cur;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) data_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic set_in(input logic [IB-1:0] m, input logic [VW-1:0] dv);
        zero_mask_in = m;
        for (int e = 0; e < IB*BS; e++) data_in[e] = dv[e*W +: W];
    endtask

    // Returns at posedge+1 of the accepting edge, data_in_valid still high
    task automatic send_vec(input logic [IB-1:0] m, input logic [VW-1:0] dv);
        bit hs;
        hs = 0;
        set_in(m, dv);
        data_in_valid = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clk);
            hs = data_in_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("in_handshake_timeout", 0, 1);
    endtask

    task automatic idle_in();
        data_in_valid = 1'b0;
        set_in(IB'($urandom), rand_vec());
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !data_out_valid) done = 1;
        end
        chk(nm, done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t  t;
        beat_t o, s;
        int    n;
        bit    stop;

        rst = 1'b0;
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        set_in('0, '0);

        tbl[0] = '{4'b1010, 2'b11, 2'd0, 2'd2, 1'b1, 16'h0000, 4'd1};
        tbl[1] = '{4'b0000, 2'b11, 2'd0, 2'd1, 1'b0, 16'h0000, 4'd2};
        tbl[2] = '{4'b0111, 2'b01, 2'd3, 2'd0, 1'b1, 16'h0030, 4'd1};
`ifdef SPARSE_COMPACT_SKIP_EMPTY_EN
        tbl[3] = '{4'b1111, 2'b00, 2'd0, 2'd0, 1'b1, 16'h0000, 4'd0};
`else
        tbl[3] = '{4'b1111, 2'b00, 2'd0, 2'd0, 1'b1, 16'h0000, 4'd1};
`endif
        tbl[4] = '{4'b1101, 2'b01, 2'd1, 2'd0, 1'b1, 16'h0010, 4'd1};
        tbl[5] = '{4'b0100, 2'b11, 2'd0, 2'd1, 1'b0, 16'h0000, 4'd2};
        tbl[6] = '{4'b1000, 2'b11, 2'd0, 2'd1, 1'b0, 16'h0000, 4'd2};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", data_out_valid, 0);
        chk("rst_outputs", sample_beat(), '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", data_in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            t = tbl[i];
            obs_q.delete();
            send_vec(t.mask, ramp_vec());
            idle_in();
            drain("tbl_drain");
            chk("tbl_beats", obs_q.size(), t.beats);
            if (obs_q.size() > 0) begin
                o = obs_q[0];
                chk("tbl_bv", o.bv, t.bv);
                chk("tbl_idx0", o.idx[IW-1:0], t.i0);
                chk("tbl_idx1", o.idx[2*IW-1:IW], t.i1);
                chk("tbl_last", o.last, t.last);
                chk("tbl_lane0_elem0", o.d[W-1:0], t.d0);
            end else begin
                for (int k = 0; k < 3; k++) begin
                    chk("skip_ready", {data_in_ready, data_out_valid}, 2'b10);
                    @(posedge clk);
                    #1;
                end
            end
        end

        // two beats back to back; input opens only on the last one
        send_vec(4'b0000, ramp_vec());
        idle_in();
        chk("seq_beat1", {data_out_valid, data_out_last, data_in_ready}, 3'b100);
        @(posedge clk);
        #1;
        chk("seq_beat2", {data_out_valid, data_out_last, data_in_ready}, 3'b111);
        drain("seq_drain");

        // backpressure hold then three vectors streamed with no bubble
        data_out_ready = 1'b0;
        send_vec(4'b0000, rand_vec());
        idle_in();
        s = sample_beat();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {data_out_valid, sample_beat()}, {1'b1, s});
        end
        v1 = rand_vec();
        v2 = rand_vec();
        v3 = rand_vec();
        data_out_ready = 1'b1;
        fork
            begin
                send_vec(4'b0000, v1);
                send_vec(4'b1001, v2);
                send_vec(4'b0110, v3);
                idle_in();
            end
        join_none
        n = 0;
        stop = 0;
        for (int k = 0; k < 50 && !stop; k++) begin
            @(negedge clk);
            if (data_out_valid) n++;
            else stop = 1;
        end
        chk("stream_no_bubble", n, 6);
        drain("stream_drain");

        // asynchronous reset in the middle of the second beat
        send_vec(4'b0000, rand_vec());
        idle_in();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", data_out_valid, 0);
        chk("async_rst_outputs", sample_beat(), '0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst2", {data_in_ready, data_out_valid}, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        chk("no_resume", data_out_valid, 0);

        // randomized traffic with random downstream stalls
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            send_vec(IB'($urandom), rand_vec());
            idle_in();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 0;
        data_out_ready = 1'b1;
        drain("rand_drain");
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/sparse_block_compact_stream.md
Name: sparse_block_compact_stream

Overview:
- Streaming, handshaked successor to the combinational block-sparse multiplexer.
- Accepts a vector of IN_BLOCK_NUM blocks with a per-block zero mask, and emits only the non-zero blocks over OUT_BLOCK_NUM output lanes.
- When there are more non-zero blocks than lanes, it emits them over as many beats as needed.
- Each lane carries its source block index, so the downstream sparse MAC can gather the matching weights.

Parameters:
- IN_BLOCK_NUM, 4: blocks per input vector.
- BLOCK_SIZE, 4: elements per block.
- OUT_BLOCK_NUM, 2: block lanes per output beat. Must satisfy 1 <= OUT_BLOCK_NUM <= IN_BLOCK_NUM; any other value is an elaboration error.
- IN_WIDTH, 16: bits per element.
- IDX_WIDTH, max(1,$clog2(IN_BLOCK_NUM)): block index width. Derived; do not override.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- zero_mask_in  input  IN_BLOCK_NUM  bit b = 1 means block b is all-zero and is skipped.
- data_in  input  IN_WIDTH x (IN_BLOCK_NUM*BLOCK_SIZE)  unpacked element array; block b = elements b*BLOCK_SIZE .. b*BLOCK_SIZE+BLOCK_SIZE-1.
- data_in_valid  input  1  input vector valid.
- data_in_ready  output  1  input vector accepted when valid && ready.
- data_out  output  IN_WIDTH x (OUT_BLOCK_NUM*BLOCK_SIZE)  packed non-zero blocks; lane l = elements l*BLOCK_SIZE ..
- data_out_block_idx  output  IDX_WIDTH x OUT_BLOCK_NUM  source block index per lane.
- data_out_block_valid  output  OUT_BLOCK_NUM  per-lane occupancy.
- data_out_last  output  1  final beat of the current vector.
- data_out_valid  output  1  beat valid.
- data_out_ready  input  1  downstream accepts beat.

Behaviour:
- Reset (rst=0, asynchronous): every output register clears to 0, data_out_valid=0, state IDLE, and the held vector and remaining mask are discarded. data_in_ready=1 from the first clock after rst returns to 1.
- States:
  - IDLE: nothing held.
  - EMIT: a vector is held and beats are outstanding.
  - IDLE -> EMIT on an input handshake. EMIT -> IDLE when the last beat is accepted with no new vector arriving. EMIT stays EMIT when the last beat is accepted in the same cycle as a new input handshake.
- data_in_ready = (state==IDLE) || (data_out_valid && data_out_ready && data_out_last). This is a combinational path from data_out_ready and is intentional: it gives back-to-back vectors with no bubble.
- Latency: the first beat is valid on the cycle after the input handshake. Each following beat appears in the cycle after the previous one is accepted.
- Beat formation:
  - Internal remaining mask = zero_mask_in at capture.
  - Each beat takes the lowest-indexed OUT_BLOCK_NUM blocks whose remaining-mask bit is 0, places them in lanes 0.. in ascending order, then sets those bits to 1.
  - Unoccupied lanes: data 0, idx 0, block_valid 0.
  - data_out_last=1 when no 0 bit remains after forming the beat.
- Beats per vector = max(1, ceil(nnz/OUT_BLOCK_NUM)).
- All-zero vector (mask all ones): exactly one beat with block_valid all 0 and last=1.
- Backpressure: while data_out_valid && !data_out_ready, all data_out* outputs hold stable. data_out_valid never drops without a handshake.
- data_in is sampled only at the handshake. Input changes afterwards have no effect on the held vector.
- Priority selection must be loop-based over IN_BLOCK_NUM; no fixed-size case tables.

Optional Feature:
- Macro SPARSE_COMPACT_SKIP_EMPTY_EN.
- Defined: an all-zero vector is consumed without producing any beat. State stays or returns to IDLE and data_in_ready stays 1.
- Undefined: an all-zero vector emits one empty beat with last=1, as in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Defaults, mask 4'b1010, blocks filled with value = 16*b + element -> one beat a cycle after accept: lane0 = block0, lane1 = block2, idx {0,2}, block_valid 2'b11, last=1.
- Mask 4'b0000, ready held 1 -> two consecutive beats: (idx 0,1, last=0) then (idx 2,3, last=1). data_in_ready=1 only on the second beat's cycle.
- Mask 4'b0111 -> one beat: lane0 = block3, idx0 = 3, block_valid 2'b01, lane1 data all 0, last=1.
- Mask 4'b1111:
  - Macro undefined -> one beat, block_valid 2'b00, last=1.
  - Macro defined -> no data_out_valid, and data_in_ready stays 1 throughout.
- Flow control:
  - Hold data_out_ready=0 for 5 cycles on the first beat of mask 4'b0000 -> outputs remain stable.
  - Then stream three vectors with ready=1 -> zero idle cycles between vectors and index order preserved.
- Drive rst=0 mid-cycle during the second beat -> all outputs are 0 immediately, without waiting for a clock edge. After release, data_in_ready=1 and the interrupted vector is never resumed.
